ctrl_fsm: RTL
=============

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: ins  in  32  instruction word from yIF, valid during FETCH.
REQ-004 SHALL have ports: zero  in  1  ALU zero flag from yEX.
REQ-005 SHALL have ports: mem_ready  in  1  data-memory completion handshake.
REQ-006 SHALL have ports: RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  out  1 each  datapath controls.
REQ-007 SHALL have ports: op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-008 SHALL have ports: IRWrite, PCWrite  out  1 each; PCSel  out  2  (00 PC+4, 01 branch, 10 jTarget).
REQ-009 SHALL have ports: state  out  3  current state; halted  out  1  sticky illegal-opcode flag.
REQ-010 SHALL have one clock; reset SHALL be synchronous and active-low.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; state SHALL be a registered Moore machine.
REQ-012 FETCH: IRWrite=1, PCWrite=1, PCSel=00; latch ins[6:0], ins[14:12], ins[30] internally; next DECODE.
REQ-013 DECODE: opcodes 0x33, 0x13, 0x03, 0x23, 0x63 -> EXEC; 0x6F -> WB; any other -> HALT.
REQ-014 EXEC, R-type 0x33: ALUSrc=0; op from funct3/ins[30] (000 + bit30=0 add, 000 + bit30=1 sub, 111 and, 110 or, 010 slt); next WB.
REQ-015 EXEC, I-arith 0x13: ALUSrc=1; same funct3 map with bit30 ignored (add only); next WB.
REQ-016 EXEC, load 0x03 or store 0x23: ALUSrc=1, op=010; next MEM.
REQ-017 EXEC, branch 0x63 (beq): ALUSrc=0, op=110; PCWrite=zero, PCSel=01; next FETCH.
REQ-018 MEM: MemRead=1 for load, MemWrite=1 for store; hold in MEM while mem_ready=0; on mem_ready=1, load -> WB, store -> FETCH.
REQ-019 WB: RegWrite=1; Mem2Reg=1 for load, otherwise 0; for 0x6F also PCWrite=1, PCSel=10; next FETCH.
REQ-020 Unlisted outputs in any state SHALL be 0; op SHALL default to 010.
REQ-021 Latency SHALL be: R/I 4 cycles, load 5+waits, store 4+waits, branch 3, jal 3.
REQ-022 HALT: all controls 0, halted=1; HALT SHALL be left only via reset.
REQ-023 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite SHALL never be 1 while MemWrite=1.
REQ-024 mem_ready SHALL be ignored outside MEM.

Reset
REQ-025 While rst_n=0 at a rising edge: state=FETCH, halted=0, latched fields 0, counters 0.
REQ-026 Reset SHALL take priority over every transition, including mid-MEM wait and HALT; MemRead/MemWrite SHALL be 0 in the cycle after reset.

Configuration
REQ-027 Macro CTRL_FSM_PERF_EN SHALL, when defined, add outputs cyc_cnt (32) and ins_cnt (32).
REQ-028 With CTRL_FSM_PERF_EN: cyc_cnt SHALL increment every non-reset cycle outside HALT; ins_cnt SHALL increment on each DECODE-to-legal-state transition; both wrap at 2^32 to 0.
REQ-029 Without CTRL_FSM_PERF_EN: ports and counters absent; all other behaviour identical.

Verification
REQ-030 add x3,x1,x2 (0x002081B3) after reset -> states 0,1,2,4,0; op=010, ALUSrc=0 in EXEC; RegWrite=1 only in WB.
REQ-031 lw (opcode 0x03), mem_ready low 2 cycles -> MEM held 3 cycles, MemRead=1 throughout, then WB with Mem2Reg=1; total 7 cycles.
REQ-032 beq with zero=1 -> PCWrite=1, PCSel=01 in EXEC; with zero=0 -> PCWrite=0; back to FETCH after 3 cycles.
REQ-033 ins=0xFFFFFFFF -> DECODE -> HALT, halted=1 stays; rst_n=0 one edge -> FETCH, halted=0.
REQ-034 rst_n=0 asserted during MEM wait of sw -> next state FETCH, MemWrite=0.
REQ-035 CTRL_FSM_PERF_EN defined, 3 add instructions -> ins_cnt=3, cyc_cnt=12.

Source files
------------

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle RV32 subset control FSM (optional perf counters: CTRL_FSM_PERF_EN)
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        Mem2Reg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  op,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSel,
    output logic [2:0]  state,
    output logic        halted
`ifdef CTRL_FSM_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ins_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LD  = 7'h03;
    localparam logic [6:0] OPC_ST  = 7'h23;
    localparam logic [6:0] OPC_BR  = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    state_t     cur;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       b30;
    logic       pcw_r;
    logic       br_en;

    logic unused_ins_bits;
    assign unused_ins_bits = ^{ins[31], ins[29:15], ins[11:7]};

    assign state = cur;
    // beq resolves PCWrite from the ALU zero flag produced in the same EXEC cycle
    assign PCWrite = pcw_r | (br_en & zero);

    function automatic logic [2:0] alu_op(input logic [2:0] f, input logic sub);
        case (f)
            3'b000:  alu_op = sub ? 3'b110 : 3'b010;
            3'b111:  alu_op = 3'b000;
            3'b110:  alu_op = 3'b001;
            3'b010:  alu_op = 3'b111;
            default: alu_op = 3'b010;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur      <= S_FETCH;
            halted   <= 1'b0;
            opc      <= '0;
            f3       <= '0;
            b30      <= 1'b0;
            RegWrite <= 1'b0;
            ALUSrc   <= 1'b0;
            Mem2Reg  <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            op       <= 3'b010;
            IRWrite  <= 1'b1;
            pcw_r    <= 1'b1;
            PCSel    <= 2'b00;
            br_en    <= 1'b0;
`ifdef CTRL_FSM_PERF_EN
            cyc_cnt  <= '0;
            ins_cnt  <= '0;
`endif
        end else begin
            // outputs are computed for the state being entered
            RegWrite <= 1'b0;
            ALUSrc   <= 1'b0;
            Mem2Reg  <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            op       <= 3'b010;
            IRWrite  <= 1'b0;
            pcw_r    <= 1'b0;
            PCSel    <= 2'b00;
            br_en    <= 1'b0;
`ifdef CTRL_FSM_PERF_EN
            if (cur != S_HALT)
                cyc_cnt <= cyc_cnt + 32'd1;
`endif
            case (cur)
                S_FETCH: begin
                    opc <= ins[6:0];
                    f3  <= ins[14:12];
                    b30 <= ins[30];
                    cur <= S_DECODE;
                end
                S_DECODE: begin
`ifdef CTRL_FSM_PERF_EN
                    if (opc inside {OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL})
                        ins_cnt <= ins_cnt + 32'd1;
`endif
                    case (opc)
                        OPC_R, OPC_I: begin
                            cur    <= S_EXEC;
                            ALUSrc <= (opc == OPC_I);
                            op     <= alu_op(f3, b30 & (opc == OPC_R));
                        end
                        OPC_LD, OPC_ST: begin
                            cur    <= S_EXEC;
                            ALUSrc <= 1'b1;
                        end
                        OPC_BR: begin
                            cur   <= S_EXEC;
                            op    <= 3'b110;
                            PCSel <= 2'b01;
                            br_en <= 1'b1;
                        end
                        OPC_JAL: begin
                            cur      <= S_WB;
                            RegWrite <= 1'b1;
                            pcw_r    <= 1'b1;
                            PCSel    <= 2'b10;
                        end
                        default: begin
                            cur    <= S_HALT;
                            halted <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (opc == OPC_LD || opc == OPC_ST) begin
                        cur      <= S_MEM;
                        MemRead  <= (opc == OPC_LD);
                        MemWrite <= (opc == OPC_ST);
                    end else if (opc == OPC_R || opc == OPC_I) begin
                        cur      <= S_WB;
                        RegWrite <= 1'b1;
                    end else begin
                        cur     <= S_FETCH;
                        IRWrite <= 1'b1;
                        pcw_r   <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (!mem_ready) begin
                        MemRead  <= (opc == OPC_LD);
                        MemWrite <= (opc == OPC_ST);
                    end else if (opc == OPC_LD) begin
                        cur      <= S_WB;
                        RegWrite <= 1'b1;
                        Mem2Reg  <= 1'b1;
                    end else begin
                        cur     <= S_FETCH;
                        IRWrite <= 1'b1;
                        pcw_r   <= 1'b1;
                    end
                end
                S_HALT: begin
                    cur    <= S_HALT;
                    halted <= 1'b1;
                end
                default: begin
                    cur     <= S_FETCH;
                    IRWrite <= 1'b1;
                    pcw_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule
